// File: rtl/register_pkg.sv
// Shared register-file sizing and tag types for the rename stage.
// Every rename-stage block imports this package.
package register_pkg;

  localparam int PREG_NUM = 64;
  localparam int ARCH_NUM = 32;
  localparam int PREG_W   = 6;
  localparam int FL_PTR_W = 7;

  typedef logic [PREG_W-1:0]   physical_reg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

  localparam physical_reg_t PREG_ZERO = physical_reg_t'(0);
  localparam fl_ptr_t       FL_FULL   = fl_ptr_t'(PREG_NUM);

  // Free-list slot i holds r(ARCH_NUM+i) out of reset; r0..r31 back the architected x0..x31.
  function automatic physical_reg_t reset_tag(input int idx);
    return physical_reg_t'(ARCH_NUM + idx);
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit handshake bundle for the physical register free list.
interface phys_reg_free_list_if;
  import register_pkg::*;

  logic          alloc_en;
  physical_reg_t alloc_preg;
  logic          free_avail;
  logic          commit_en;
  logic          release_en;
  physical_reg_t release_preg;
  logic          flush;
  fl_ptr_t       free_count;
  logic          err;

  modport master (
    output alloc_en, commit_en, release_en, release_preg, flush,
    input  alloc_preg, free_avail, free_count, err
  );

  modport slave (
    input  alloc_en, commit_en, release_en, release_preg, flush,
    output alloc_preg, free_avail, free_count, err
  );

endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with speculative and committed heads.
// A flush rewinds the speculative head to the committed head.
module phys_reg_free_list
  import register_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  phys_reg_free_list_if.slave  fl
);

  physical_reg_t mem_q [PREG_NUM];
  physical_reg_t mem_d [PREG_NUM];
  fl_ptr_t       spec_head_q, spec_head_d;
  fl_ptr_t       commit_head_q, commit_head_d;
  fl_ptr_t       tail_q, tail_d;
  logic          err_q, err_d;

  fl_ptr_t       free_count_s;
  fl_ptr_t       in_list_s;
  logic          empty_s;
  logic          full_s;
  logic          alloc_fire_s;
  logic          alloc_err_s;
  logic          commit_fire_s;
  logic          commit_err_s;
  logic          rel_valid_s;
  logic          rel_fire_s;
  logic          rel_err_s;

  // Occupancy and per-request fire/error qualification from registered state only.
  always_comb begin
    free_count_s  = tail_q - spec_head_q;
    in_list_s     = tail_q - commit_head_q;
    empty_s       = (free_count_s == fl_ptr_t'(0));
    full_s        = (in_list_s == FL_FULL);
    alloc_fire_s  = fl.alloc_en && !empty_s && !fl.flush;
    alloc_err_s   = fl.alloc_en && empty_s && !fl.flush;
    commit_fire_s = fl.commit_en && (commit_head_q != spec_head_q);
    commit_err_s  = fl.commit_en && (commit_head_q == spec_head_q);
    rel_valid_s   = fl.release_en && (fl.release_preg != PREG_ZERO);
    rel_fire_s    = rel_valid_s && !full_s;
    rel_err_s     = rel_valid_s && full_s;
  end

  // Next-state: pointer advances, tag write-back and sticky error accumulation.
  always_comb begin
    mem_d         = mem_q;
    spec_head_d   = spec_head_q;
    commit_head_d = commit_head_q;
    tail_d        = tail_q;
    err_d         = err_q || alloc_err_s || commit_err_s || rel_err_s;

    if (commit_fire_s) begin
      commit_head_d = commit_head_q + fl_ptr_t'(1);
    end else begin
      commit_head_d = commit_head_q;
    end

    // A flush rewinds to the post-commit head so a same-cycle commit is not lost.
    if (fl.flush) begin
      spec_head_d = commit_head_d;
    end else if (alloc_fire_s) begin
      spec_head_d = spec_head_q + fl_ptr_t'(1);
    end else begin
      spec_head_d = spec_head_q;
    end

    if (rel_fire_s) begin
      mem_d[tail_q[PREG_W-1:0]] = fl.release_preg;
      tail_d                    = tail_q + fl_ptr_t'(1);
    end else begin
      tail_d = tail_q;
    end
  end

  // State registers; only the lower half of storage carries a reset image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_NUM; i++) begin
        mem_q[i] <= reset_tag(i);
      end
      spec_head_q   <= fl_ptr_t'(0);
      commit_head_q <= fl_ptr_t'(0);
      tail_q        <= fl_ptr_t'(ARCH_NUM);
      err_q         <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      err_q         <= err_d;
    end
  end

  assign fl.alloc_preg = mem_q[spec_head_q[PREG_W-1:0]];
  assign fl.free_count = free_count_s;
  assign fl.free_avail = !empty_s;
  assign fl.err        = err_q;

endmodule
